// File: rtl/mips_mdu.sv
// Iterative MIPS HI/LO multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Optional MIPS_MDU_FAST_MULT_EN replaces the multiply iterations with a single-cycle multiplier.
module mips_mdu #(
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [5:0]        i_op,
   input  logic [DATA_W-1:0] i_op1,
   input  logic [DATA_W-1:0] i_op2,
   output logic [DATA_W-1:0] o_hi,
   output logic [DATA_W-1:0] o_lo,
   output logic              o_busy,
   output logic              o_done
);

   localparam logic [5:0] OP_MULT  = 6'b011000;
   localparam logic [5:0] OP_MULTU = 6'b011001;
   localparam logic [5:0] OP_DIV   = 6'b011010;
   localparam logic [5:0] OP_DIVU  = 6'b011011;
   localparam logic [5:0] OP_MTHI  = 6'b010001;
   localparam logic [5:0] OP_MTLO  = 6'b010011;
   localparam logic [5:0] CNT_LAST = 6'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t                   state, state_nxt;
   logic [5:0]               cnt;
   logic [DATA_W-1:0]        hi, lo;
   logic                     is_div, neg_q, neg_r, div_zero;
   logic [DATA_W-1:0]        opnd_b;
   logic [2*DATA_W-1:0]      acc;

   logic signed [DATA_W-1:0] op1_s, op2_s;
   logic                     op_signed, op_arith, accept, start_arith, fast_mul;
   logic [DATA_W:0]          mul_sum, div_shift, div_diff;
   logic [2*DATA_W-1:0]      mul_step, div_step, mag_p, mul_res;
   logic [DATA_W-1:0]        hi_fix, lo_fix;

   function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                   input logic is_signed);
      return (is_signed && (v < 0)) ? -v : v;
   endfunction

   function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   function automatic logic [2*DATA_W-1:0] cond_neg_wide(input logic [2*DATA_W-1:0] v,
                                                         input logic neg);
      return neg ? -v : v;
   endfunction

   assign op1_s       = i_op1;
   assign op2_s       = i_op2;
   assign op_signed   = ~i_op[0];
   assign op_arith    = (i_op == OP_MULT) || (i_op == OP_MULTU) ||
                        (i_op == OP_DIV)  || (i_op == OP_DIVU);
   assign accept      = i_start && ((state == IDLE) || (state == DONE));
   assign start_arith = accept && op_arith;

`ifdef MIPS_MDU_FAST_MULT_EN
   assign fast_mul = ~i_op[1];
   assign mag_p    = is_div ? acc : ({{DATA_W{1'b0}}, opnd_b} * {{DATA_W{1'b0}}, acc[DATA_W-1:0]});
`else
   assign fast_mul = 1'b0;
   assign mag_p    = acc;
`endif

   // multiply step: acc = {partial product, remaining multiplier bits}
   assign mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} +
                      (acc[0] ? {1'b0, opnd_b} : {(DATA_W+1){1'b0}});
   assign mul_step  = {mul_sum, acc[DATA_W-1:1]};

   // divide step: acc = {partial remainder, dividend shifting into quotient}
   assign div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
   assign div_diff  = div_shift - {1'b0, opnd_b};
   assign div_step  = div_diff[DATA_W] ? {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                                       : {div_diff[DATA_W-1:0],  acc[DATA_W-2:0], 1'b1};

   assign mul_res = cond_neg_wide(mag_p, neg_q);
   assign hi_fix  = is_div ? cond_neg(acc[2*DATA_W-1:DATA_W], neg_r) : mul_res[2*DATA_W-1:DATA_W];
   assign lo_fix  = is_div ? (div_zero ? {DATA_W{1'b1}} : cond_neg(acc[DATA_W-1:0], neg_q))
                           : mul_res[DATA_W-1:0];

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      o_busy    = 1'b0;
      o_done    = 1'b0;
      case (state)
         IDLE: begin
            if (start_arith) state_nxt = fast_mul ? FIX : CALC;
         end
         CALC: begin
            o_busy = 1'b1;
            if (cnt == CNT_LAST) state_nxt = FIX;
         end
         FIX: begin
            o_busy    = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            o_done    = 1'b1;
            state_nxt = start_arith ? (fast_mul ? FIX : CALC) : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hi       <= '0;
         lo       <= '0;
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         cnt <= (state == CALC) ? cnt + 6'd1 : 6'd0;
         if (accept && (i_op == OP_MTHI)) hi <= i_op1;
         if (accept && (i_op == OP_MTLO)) lo <= i_op1;
         if (start_arith) begin
            is_div   <= i_op[1];
            neg_q    <= op_signed & (i_op1[DATA_W-1] ^ i_op2[DATA_W-1]);
            neg_r    <= op_signed & i_op[1] & i_op1[DATA_W-1];
            div_zero <= i_op[1] & (i_op2 == '0);
         end
         if (state == FIX) begin
            hi <= hi_fix;
            lo <= lo_fix;
         end
      end
   end

   // operand latch on acceptance, then one iteration per CALC cycle
   always_ff @(posedge i_clk) begin
      if (start_arith) begin
         if (i_op[1]) begin
            opnd_b <= magnitude(op2_s, op_signed);
            acc    <= {{DATA_W{1'b0}}, magnitude(op1_s, op_signed)};
         end else begin
            opnd_b <= magnitude(op1_s, op_signed);
            acc    <= {{DATA_W{1'b0}}, magnitude(op2_s, op_signed)};
         end
      end else if (state == CALC) begin
         acc <= is_div ? div_step : mul_step;
      end
   end

   assign o_hi = hi;
   assign o_lo = lo;

endmodule

// File: tb/tb_mips_mdu.sv
// Scoreboard bench for mips_mdu: results from a behavioural model, latency and handshake checks.
module tb_mips_mdu;

   localparam logic [5:0] OP_MULT  = 6'b011000;
   localparam logic [5:0] OP_MULTU = 6'b011001;
   localparam logic [5:0] OP_DIV   = 6'b011010;
   localparam logic [5:0] OP_DIVU  = 6'b011011;
   localparam logic [5:0] OP_MTHI  = 6'b010001;
   localparam logic [5:0] OP_MTLO  = 6'b010011;
`ifdef MIPS_MDU_FAST_MULT_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        start = 1'b0;
   logic [5:0]  op    = '0;
   logic [31:0] op1   = '0;
   logic [31:0] op2   = '0;
   logic [31:0] hi, lo;
   logic        busy, done;

   int checks   = 0;
   int errors   = 0;
   int edge_cnt = 0;
   int acc_edge = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic [63:0] sb[$];

   mips_mdu dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_start(start),
      .i_op   (op),
      .i_op1  (op1),
      .i_op2  (op2),
      .o_hi   (hi),
      .o_lo   (lo),
      .o_busy (busy),
      .o_done (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   function automatic logic [63:0] model(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] xe, ye;
      logic signed [31:0] sx, sy, q, r;
      model = '0;
      case (o)
         OP_MULT: begin
            xe = {{32{x[31]}}, x};
            ye = {{32{y[31]}}, y};
            model = xe * ye;
         end
         OP_MULTU: model = {32'b0, x} * {32'b0, y};
         OP_DIV: begin
            if (y == 32'h0) model = {x, 32'hFFFFFFFF};
            else if (x == 32'h80000000 && y == 32'hFFFFFFFF) model = {32'h0, 32'h80000000};
            else begin
               sx = x; sy = y;
               q = sx / sy;
               r = sx % sy;
               model = {r, q};
            end
         end
         OP_DIVU: begin
            if (y == 32'h0) model = {x, 32'hFFFFFFFF};
            else model = {x % y, x / y};
         end
         default: model = '0;
      endcase
   endfunction

   // drive one request at a falling edge; returns at the falling edge after acceptance
   task automatic issue(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
      op = o; op1 = x; op2 = y; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      acc_edge = edge_cnt;
   endtask

   task automatic wait_done(output int lat, output int busy_n);
      int n;
      n = 0; lat = -1; busy_n = 0;
      while (n < 100 && lat < 0) begin
         if (busy) busy_n++;
         if (done) lat = edge_cnt - acc_edge;
         else begin
            @(posedge clk);
            @(negedge clk);
            n++;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
      checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_ctl busy=%b done=%b want 0 0", busy, done); end
      rst = 1'b0;
      m_hi = '0; m_lo = '0;
   endtask

   task automatic test_arith_ops();
      logic [5:0]  vop[12];
      logic [31:0] va[12], vb[12];
      logic [63:0] exp;
      int lat, bn, exp_lat;
      vop[0] = OP_MULT;  va[0] = 32'hFFFFFFFE; vb[0] = 32'h00000003;
      vop[1] = OP_MULTU; va[1] = 32'hFFFFFFFF; vb[1] = 32'hFFFFFFFF;
      vop[2] = OP_DIV;   va[2] = 32'hFFFFFFF9; vb[2] = 32'h00000002;
      vop[3] = OP_DIVU;  va[3] = 32'd100;      vb[3] = 32'h0;
      vop[4] = OP_DIV;   va[4] = 32'hFFFFFF9C; vb[4] = 32'h0;
      vop[5] = OP_DIV;   va[5] = 32'd7;        vb[5] = 32'hFFFFFFFE;
      vop[6] = OP_MULT;  va[6] = 32'h80000000; vb[6] = 32'h80000000;
      vop[7] = OP_DIVU;  va[7] = 32'hFFFFFFFF; vb[7] = 32'h00000001;
      for (int i = 8; i < 12; i++) begin
         case ($urandom_range(0, 3))
            0: vop[i] = OP_MULT;
            1: vop[i] = OP_MULTU;
            2: vop[i] = OP_DIV;
            default: vop[i] = OP_DIVU;
         endcase
         va[i] = $urandom;
         vb[i] = $urandom_range(0, 1) ? $urandom : $urandom_range(1, 1000);
      end
      for (int i = 0; i < 12; i++) begin
         sb.push_back(model(vop[i], va[i], vb[i]));
         issue(vop[i], va[i], vb[i]);
         checks++;
         if ({hi, lo} !== {m_hi, m_lo}) begin
            errors++; $display("FAIL hold_%0d got %h_%h want %h_%h", i, hi, lo, m_hi, m_lo);
         end
         wait_done(lat, bn);
         exp_lat = vop[i][1] ? 33 : MUL_LAT;
         checks++;
         if (lat !== exp_lat) begin errors++; $display("FAIL latency_%0d got %0d want %0d", i, lat, exp_lat); end
         checks++;
         if (bn !== exp_lat) begin errors++; $display("FAIL busy_len_%0d got %0d want %0d", i, bn, exp_lat); end
         exp = sb.pop_front();
         checks++;
         if ({hi, lo} !== exp) begin
            errors++; $display("FAIL result_%0d op=%b a=%h b=%h got %h_%h want %h_%h",
                               i, vop[i], va[i], vb[i], hi, lo, exp[63:32], exp[31:0]);
         end
         m_hi = exp[63:32]; m_lo = exp[31:0];
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_pulse_%0d done=%b busy=%b want 0 0", i, done, busy);
         end
      end
   endtask

   task automatic test_mt();
      op = OP_MTHI; op1 = 32'h12345678; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++; if (hi !== 32'h12345678 || lo !== m_lo) begin errors++; $display("FAIL mthi got %h_%h want 12345678_%h", hi, lo, m_lo); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_ctl busy=%b done=%b want 0 0", busy, done); end
      op = OP_MTLO; op1 = 32'hCAFEBABE;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checks++; if (hi !== 32'h12345678 || lo !== 32'hCAFEBABE) begin errors++; $display("FAIL mtlo got %h_%h want 12345678_cafebabe", hi, lo); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mtlo_ctl busy=%b done=%b want 0 0", busy, done); end
      m_hi = 32'h12345678; m_lo = 32'hCAFEBABE;
   endtask

   task automatic test_invalid();
      int bad;
      bad = 0;
      op = 6'b100000; op1 = 32'hDEADBEEF; op2 = 32'h1; start = 1'b1;
      @(posedge clk);
      op = 6'b010000;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) begin
         if (busy !== 1'b0 || done !== 1'b0) bad++;
         @(posedge clk);
         @(negedge clk);
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL invalid_ctl active cycles got %0d want 0", bad); end
      checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL invalid_regs got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
   endtask

   task automatic test_div_overflow_ignore();
      logic [63:0] exp;
      int lat, bn, bad;
      bad = 0;
      sb.push_back(model(OP_DIV, 32'h80000000, 32'hFFFFFFFF));
      issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      repeat (5) begin @(posedge clk); @(negedge clk); end
      op = OP_MULTU; op1 = 32'd3; op2 = 32'd5; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bn);
      checks++; if (lat !== 33) begin errors++; $display("FAIL ovf_latency got %0d want 33", lat); end
      exp = sb.pop_front();
      checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL ovf_result got %h_%h want %h_%h", hi, lo, exp[63:32], exp[31:0]); end
      m_hi = exp[63:32]; m_lo = exp[31:0];
      repeat (40) begin
         @(posedge clk);
         @(negedge clk);
         if (busy !== 1'b0 || done !== 1'b0) bad++;
      end
      checks++; if (bad != 0 || hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL ignored_start active=%0d regs %h_%h want 0 %h_%h", bad, hi, lo, m_hi, m_lo); end
   endtask

   task automatic test_reset_abort();
      int pulses;
      pulses = 0;
      issue(OP_DIVU, 32'd1000, 32'd7);
      repeat (9) begin @(posedge clk); @(negedge clk); end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL abort_regs got %h_%h want 0_0", hi, lo); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_ctl busy=%b done=%b want 0 0", busy, done); end
      m_hi = '0; m_lo = '0;
      repeat (40) begin
         @(posedge clk);
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      checks++; if (pulses != 0 || hi !== 32'h0) begin errors++; $display("FAIL abort_done pulses=%0d hi=%h want 0 0", pulses, hi); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp;
      int lat, bn;
      sb.push_back(model(OP_MULTU, 32'h12345678, 32'h9ABCDEF0));
      issue(OP_MULTU, 32'h12345678, 32'h9ABCDEF0);
      wait_done(lat, bn);
      checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL b2b_lat1 got %0d want %0d", lat, MUL_LAT); end
      exp = sb.pop_front();
      checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL b2b_res1 got %h_%h want %h_%h", hi, lo, exp[63:32], exp[31:0]); end
      m_hi = exp[63:32]; m_lo = exp[31:0];
      sb.push_back(model(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF));
      issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy got %b want 1", busy); end
      wait_done(lat, bn);
      checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL b2b_lat2 got %0d want %0d", lat, MUL_LAT); end
      exp = sb.pop_front();
      checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL b2b_res2 got %h_%h want %h_%h", hi, lo, exp[63:32], exp[31:0]); end
      m_hi = exp[63:32]; m_lo = exp[31:0];
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_arith_ops();
      test_mt();
      test_invalid();
      test_div_overflow_ignore();
      test_reset_abort();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
